// File: rtl/decoder_pkg.sv
// Shared types and opcode/ModRM field constants for the fetch/align front end.
// Used by fetch_align_ctrl and instr_length_calc.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [7:0] OP_ADD_RM8_R8  = 8'h00;
  localparam logic [7:0] OP_ADD_RM32_R  = 8'h01;
  localparam logic [7:0] OP_ADD_R8_RM8  = 8'h02;
  localparam logic [7:0] OP_ADD_R_RM32  = 8'h03;
  localparam logic [7:0] OP_ADD_AL_IB   = 8'h04;
  localparam logic [7:0] OP_ADD_EAX_ID  = 8'h05;
  localparam logic [7:0] OP_ESCAPE      = 8'h0F;
  localparam logic [7:0] OP_GRP1_RM8_IB = 8'h80;
  localparam logic [7:0] OP_GRP1_RM_ID  = 8'h81;
  localparam logic [7:0] OP_GRP1_RM_IB  = 8'h83;
  localparam logic [7:0] OP_MOV_RM8_R8  = 8'h88;
  localparam logic [7:0] OP_MOV_RM_R    = 8'h89;
  localparam logic [7:0] OP_MOV_R8_RM8  = 8'h8A;
  localparam logic [7:0] OP_MOV_R_RM    = 8'h8B;
  localparam logic [7:0] OP_NOP         = 8'h90;
  localparam logic [7:0] OP_RET         = 8'hC3;

  localparam logic [1:0] MOD_INDIRECT = 2'b00;
  localparam logic [1:0] MOD_DISP8    = 2'b01;
  localparam logic [1:0] MOD_DISP32   = 2'b10;
  localparam logic [1:0] MOD_REGISTER = 2'b11;

  localparam logic [2:0] RM_SIB         = 3'b100;
  localparam logic [2:0] RM_DISP32_ONLY = 3'b101;
  localparam logic [2:0] SIB_BASE_NONE  = 3'b101;

endpackage

// File: rtl/instr_length_calc.sv
// Combinational instruction length decode from the first three queue bytes.
// o_needed tells how many bytes must be present before o_len/o_illegal are meaningful.
module instr_length_calc
  import decoder_pkg::*;
(
  input  logic [7:0] i_byte0,
  input  logic [7:0] i_byte1,
  input  logic [7:0] i_byte2,
  output logic [3:0] o_len,
  output logic [1:0] o_needed,
  output logic       o_illegal
);

  logic [1:0] modField;
  logic [2:0] rmField;
  logic [2:0] sibBase;
  logic       hasSib;
  logic [3:0] modrmExt;
  logic       unusedBits;

  assign modField   = i_byte1[7:6];
  assign rmField    = i_byte1[2:0];
  assign sibBase    = i_byte2[2:0];
  assign unusedBits = ^{i_byte1[5:3], i_byte2[7:3]};

  always_comb begin
    modrmExt = 4'd0;
    hasSib   = (modField != MOD_REGISTER) && (rmField == RM_SIB);
    unique case (modField)
      MOD_INDIRECT: begin
        if (rmField == RM_DISP32_ONLY) modrmExt = 4'd4;
        else if (rmField == RM_SIB)    modrmExt = (sibBase == SIB_BASE_NONE) ? 4'd5 : 4'd1;
        else                           modrmExt = 4'd0;
      end
      MOD_DISP8:    modrmExt = hasSib ? 4'd2 : 4'd1;
      MOD_DISP32:   modrmExt = hasSib ? 4'd5 : 4'd4;
      default:      modrmExt = 4'd0;
    endcase
  end

  always_comb begin
    o_len     = 4'd1;
    o_needed  = 2'd1;
    o_illegal = 1'b0;
    case (i_byte0)
      OP_ADD_RM8_R8, OP_ADD_RM32_R, OP_ADD_R8_RM8, OP_ADD_R_RM32,
      OP_MOV_RM8_R8, OP_MOV_RM_R, OP_MOV_R8_RM8, OP_MOV_R_RM: begin
        o_len    = 4'd2 + modrmExt;
        o_needed = hasSib ? 2'd3 : 2'd2;
      end
      OP_GRP1_RM8_IB, OP_GRP1_RM_IB: begin
        o_len    = 4'd3 + modrmExt;
        o_needed = hasSib ? 2'd3 : 2'd2;
      end
      OP_GRP1_RM_ID: begin
        o_len    = 4'd6 + modrmExt;
        o_needed = hasSib ? 2'd3 : 2'd2;
      end
      OP_ADD_AL_IB:    o_len = 4'd2;
      OP_ADD_EAX_ID:   o_len = 4'd5;
      OP_NOP, OP_RET:  o_len = 4'd1;
      default:         o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_align_ctrl.sv
// Instruction fetch/align: word fetches into a byte queue, presents variable-length instructions.
// Optional statistics counters are enabled with `define FETCH_ALIGN_STATS_EN.
module fetch_align_ctrl
  import decoder_pkg::*;
#(
  parameter int BUF_BYTES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_start_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_data,
  output logic        o_instr_valid,
  output logic [95:0] o_instr_bytes,
  output logic [3:0]  o_instr_len,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_illegal,
  input  logic        i_dec_ready
`ifdef FETCH_ALIGN_STATS_EN
  ,
  output logic [31:0] o_stat_instrs,
  output logic [31:0] o_stat_stalls
`endif
);

  localparam int         AW         = $clog2(BUF_BYTES);
  localparam logic [4:0] DEPTH      = 5'(BUF_BYTES);
  localparam logic [4:0] FILL_LIMIT = 5'(BUF_BYTES - 4);

  fetch_state_e state_q, state_d;
  logic [7:0]   queue_q [BUF_BYTES];
  logic [7:0]   queue_d [BUF_BYTES];
  logic [4:0]   count_q, count_d;
  logic [31:0]  pc_q, pc_d;
  logic         memReq_q, memReq_d;
  logic [31:0]  memAddr_q, memAddr_d;
  logic         drop_q, drop_d;
  logic [31:0]  redirAddr_q, redirAddr_d;
  logic [1:0]   skip_q, skip_d;

  logic [3:0]   calcLen;
  logic [1:0]   calcNeeded;
  logic         calcIllegal;
  logic         lenKnown;
  logic         instrValid;
  logic         consume;
  logic         fill;
  logic [3:0]   shiftLen;
  logic [4:0]   base;
  logic [4:0]   src;
  logic [4:0]   dst;
  logic [4:0]   fillBytes;

  instr_length_calc u_len (
    .i_byte0   (queue_q[0]),
    .i_byte1   (queue_q[1]),
    .i_byte2   (queue_q[2]),
    .o_len     (calcLen),
    .o_needed  (calcNeeded),
    .o_illegal (calcIllegal)
  );

  // Length outputs are only trusted once opcode/ModRM/SIB bytes are all present.
  assign lenKnown   = count_q >= {3'b000, calcNeeded};
  assign instrValid = (state_q == RUN) && lenKnown && (count_q >= {1'b0, calcLen});
  assign consume    = instrValid && i_dec_ready;
  assign fill       = memReq_q && i_mem_valid && !drop_q;

  always_comb begin
    state_d     = state_q;
    queue_d     = queue_q;
    count_d     = count_q;
    pc_d        = pc_q;
    memReq_d    = memReq_q;
    memAddr_d   = memAddr_q;
    drop_d      = drop_q;
    redirAddr_d = redirAddr_q;
    skip_d      = skip_q;
    shiftLen    = consume ? calcLen : 4'd0;
    base        = count_q - {1'b0, shiftLen};
    src         = 5'd0;
    dst         = 5'd0;
    fillBytes   = fill ? (5'd4 - {3'b000, skip_q}) : 5'd0;

    if (i_start) begin
      state_d = RUN;
      count_d = 5'd0;
      pc_d    = i_start_pc;
      skip_d  = i_start_pc[1:0];
      // A request still in flight must complete before the new stream may fetch.
      if (memReq_q && !i_mem_valid) begin
        drop_d      = 1'b1;
        redirAddr_d = {i_start_pc[31:2], 2'b00};
      end else begin
        drop_d    = 1'b0;
        memReq_d  = 1'b0;
        memAddr_d = {i_start_pc[31:2], 2'b00};
      end
    end else begin
      for (int i = 0; i < BUF_BYTES; i++) begin
        src        = 5'(i) + {1'b0, shiftLen};
        queue_d[i] = (src < DEPTH) ? queue_q[src[AW-1:0]] : 8'h00;
      end
      if (fill) begin
        for (int k = 0; k < 4; k++) begin
          if (2'(k) >= skip_q) begin
            dst = base + 5'(k) - {3'b000, skip_q};
            if (dst < DEPTH) queue_d[dst[AW-1:0]] = i_mem_data[8*k +: 8];
          end
        end
      end
      count_d = base + fillBytes;
      pc_d    = pc_q + 32'(shiftLen);

      if (memReq_q && i_mem_valid) begin
        memReq_d = 1'b0;
        if (drop_q) begin
          drop_d    = 1'b0;
          memAddr_d = redirAddr_q;
        end else begin
          memAddr_d = memAddr_q + 32'd4;
          skip_d    = 2'b00;
        end
      end else if (!memReq_q && (state_q == RUN) && (count_q <= FILL_LIMIT)) begin
        memReq_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      count_q     <= 5'd0;
      pc_q        <= 32'd0;
      memReq_q    <= 1'b0;
      memAddr_q   <= 32'd0;
      drop_q      <= 1'b0;
      redirAddr_q <= 32'd0;
      skip_q      <= 2'b00;
      for (int i = 0; i < BUF_BYTES; i++) queue_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pc_q        <= pc_d;
      memReq_q    <= memReq_d;
      memAddr_q   <= memAddr_d;
      drop_q      <= drop_d;
      redirAddr_q <= redirAddr_d;
      skip_q      <= skip_d;
      queue_q     <= queue_d;
    end
  end

  for (genvar g = 0; g < 12; g++) begin : g_head
    assign o_instr_bytes[8*g +: 8] = queue_q[g];
  end

  assign o_mem_req       = memReq_q;
  assign o_mem_addr      = memAddr_q;
  assign o_instr_valid   = instrValid;
  assign o_instr_len     = lenKnown ? calcLen : 4'd0;
  assign o_instr_illegal = lenKnown && calcIllegal;
  assign o_instr_pc      = pc_q;

`ifdef FETCH_ALIGN_STATS_EN
  logic [31:0] statInstrs_q;
  logic [31:0] statStalls_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_start) begin
      statInstrs_q <= 32'd0;
      statStalls_q <= 32'd0;
    end else begin
      if (consume) statInstrs_q <= statInstrs_q + 32'd1;
      if ((state_q == RUN) && !instrValid) statStalls_q <= statStalls_q + 32'd1;
    end
  end

  assign o_stat_instrs = statInstrs_q;
  assign o_stat_stalls = statStalls_q;
`endif

endmodule
